// File: rtl/washer_pkg.sv
// Shared constants for the washer input-conditioning slice: channel
// indices into the raw pin vector and per-channel reset values.
package washer_pkg;

    localparam int NCH        = 6;
    localparam int CH_START   = 0;
    localparam int CH_DOOR    = 1;
    localparam int CH_FULL    = 2;
    localparam int CH_DRAINED = 3;
    localparam int CH_DRY     = 4;
    localparam int CH_CANCEL  = 5;

    // Door resets to "open" so the controller never sees a closed door by default
    localparam logic DOOR_RST_VAL = 1'b1;

    // Reset value of a channel's debounced stable bit
    function automatic logic chan_rst_val(input int ch);
        return (ch == CH_DOOR) ? DOOR_RST_VAL : 1'b0;
    endfunction

endpackage

// File: rtl/washer_input_cond_if.sv
// Pin/controller bundle for washer_input_cond: raw washer pins in,
// clean level/pulse controller inputs and the sensor plausibility flag out.
interface washer_input_cond_if;
    import washer_pkg::*;

    logic [NCH-1:0] raw_in;
    logic           start;
    logic           door_open;
    logic           water_full;
    logic           drained;
    logic           dry_sensor;
    logic           cancel;
    logic           sensor_err;

    // Pin side: drives the raw pins, observes the conditioned outputs
    modport master (
        output raw_in,
        input  start, door_open, water_full, drained, dry_sensor, cancel, sensor_err
    );

    // Conditioning block side
    modport slave (
        input  raw_in,
        output start, door_open, water_full, drained, dry_sensor, cancel, sensor_err
    );

endinterface

// File: rtl/washer_debounce.sv
// One washer input channel: synchroniser chain, consecutive-sample
// debounce counter and the accepted (stable) level.
module washer_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   w_s;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign o_stable = r_stable;

    // Shift the asynchronous pin through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= RST_VAL;
        end else if (w_s == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= w_s;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/washer_input_cond.sv
// Input conditioning in front of the washer controller FSM: six debounced
// channels, start/cancel request shaping and a water_full+drained
// plausibility flag.
// Optional build macro WASHER_IN_EDGE_EN turns start/cancel into one-cycle
// rising-edge pulses (start gated by open door, cancel wins over start);
// without it they are plain debounced levels.
module washer_input_cond
    import washer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    washer_input_cond_if.slave        io_pins
);

    logic [NCH-1:0] w_stable;
    logic           r_sensor_err;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        washer_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_VAL        (chan_rst_val(g))
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (io_pins.raw_in[g]),
            .o_stable(w_stable[g])
        );
    end

    // Flag a full tank that also reads drained; follows the stable bits by one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sensor_err <= 1'b0;
        end else begin
            r_sensor_err <= w_stable[CH_FULL] & w_stable[CH_DRAINED];
        end
    end

    assign io_pins.door_open  = w_stable[CH_DOOR];
    assign io_pins.water_full = w_stable[CH_FULL];
    assign io_pins.drained    = w_stable[CH_DRAINED];
    assign io_pins.dry_sensor = w_stable[CH_DRY];
    assign io_pins.sensor_err = r_sensor_err;

`ifdef WASHER_IN_EDGE_EN
    logic r_start_prev;
    logic r_cancel_prev;
    logic r_start_pulse;
    logic r_cancel_pulse;
    logic w_start_rise;
    logic w_cancel_rise;

    // Detect rising edges of the debounced start/cancel levels
    always_comb begin
        w_start_rise  = w_stable[CH_START]  & ~r_start_prev;
        w_cancel_rise = w_stable[CH_CANCEL] & ~r_cancel_prev;
    end

    // Registered request pulses: cancel has priority, start is ignored with the door open
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_prev   <= 1'b0;
            r_cancel_prev  <= 1'b0;
            r_start_pulse  <= 1'b0;
            r_cancel_pulse <= 1'b0;
        end else begin
            r_start_prev   <= w_stable[CH_START];
            r_cancel_prev  <= w_stable[CH_CANCEL];
            r_cancel_pulse <= w_cancel_rise;
            r_start_pulse  <= w_start_rise & ~w_cancel_rise & ~w_stable[CH_DOOR];
        end
    end

    assign io_pins.start  = r_start_pulse;
    assign io_pins.cancel = r_cancel_pulse;
`else
    assign io_pins.start  = w_stable[CH_START];
    assign io_pins.cancel = w_stable[CH_CANCEL];
`endif

endmodule

// File: tb/tb_washer_input_cond.sv
// Self-checking bench for washer_input_cond (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model: a raw-sample delay line plus a sliding window of the last
// DEB synced samples; a channel flips when every sample in the window
// disagrees with its accepted level. Honors WASHER_IN_EDGE_EN.
module tb_washer_input_cond;
    import washer_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_d = 1'b1;
    logic [5:0] raw_d = 6'h00;
    int         checks = 0;
    int         errors = 0;

    washer_input_cond_if pins();
    assign pins.raw_in = raw_d;

    washer_input_cond #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst    (rst_d),
        .io_pins(pins)
    );

    always #5 clk = ~clk;

    wire [6:0] obs = {pins.start, pins.door_open, pins.water_full, pins.drained,
                      pins.dry_sensor, pins.cancel, pins.sensor_err};

    // ---------------- reference model ----------------
    logic [5:0] m_q[$];     // raw samples still travelling through the synchroniser
    logic [5:0] m_hist[$];  // most recent synced samples (at most DEB)
    logic [5:0] m_stable = 6'b000010;
    logic [5:0] m_prev   = 6'b000010;
    logic       m_start = 1'b0, m_cancel = 1'b0, m_err = 1'b0;

    task automatic model_edge();
        logic [5:0] s, old_v, new_v, rise;
        bit all_diff;
        if (rst_d) begin
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(6'h00);
            m_hist.delete();
            m_stable = 6'b000010;
            m_prev   = 6'b000010;
            m_start  = 1'b0;
            m_cancel = 1'b0;
            m_err    = 1'b0;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(raw_d);
            m_hist.push_back(s);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            old_v = m_stable;
            new_v = old_v;
            for (int ch = 0; ch < 6; ch++) begin
                all_diff = (m_hist.size() == DEB);
                foreach (m_hist[j]) if (m_hist[j][ch] == old_v[ch]) all_diff = 1'b0;
                if (all_diff) new_v[ch] = ~old_v[ch];
            end
            m_err    = old_v[CH_FULL] & old_v[CH_DRAINED];
            rise     = old_v & ~m_prev;
            m_cancel = rise[CH_CANCEL];
            m_start  = rise[CH_START] & ~rise[CH_CANCEL] & ~old_v[CH_DOOR];
            m_prev   = old_v;
            m_stable = new_v;
        end
    endtask

    function automatic logic [6:0] exp_vec();
        logic st, ca;
`ifdef WASHER_IN_EDGE_EN
        st = m_start;
        ca = m_cancel;
`else
        st = m_stable[CH_START];
        ca = m_stable[CH_CANCEL];
`endif
        return {st, m_stable[CH_DOOR], m_stable[CH_FULL], m_stable[CH_DRAINED],
                m_stable[CH_DRY], ca, m_err};
    endfunction

    // One rising edge; model follows the inputs present at that edge; returns on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_d = 1'b1; raw_d = 6'h3F;
        tick(); tick();
        checks++;
        if (obs !== 7'b0100000) begin
            errors++; $display("FAIL reset_vals: got %b expected %b", obs, 7'b0100000);
        end
        rst_d = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset_follow e=%0d: got %b expected %b", e, obs, exp_vec());
            end
            if (e == 5) begin
                checks++;
                if (pins.water_full !== 1'b0) begin
                    errors++; $display("FAIL reset_early e=5: got %b expected 0", pins.water_full);
                end
            end
            if (e == 6) begin
                checks++;
                if ({pins.door_open, pins.water_full, pins.drained, pins.dry_sensor} !== 4'hF) begin
                    errors++; $display("FAIL reset_levels e=6: got %b expected 1111",
                        {pins.door_open, pins.water_full, pins.drained, pins.dry_sensor});
                end
            end
        end
    endtask

    task automatic test_latency();
        rst_d = 1'b1; raw_d = 6'h00; tick();
        rst_d = 1'b0;
        for (int e = 0; e < 8; e++) tick();
        raw_d[CH_FULL] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL latency_model e=%0d: got %b expected %b", e, obs, exp_vec());
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (pins.water_full !== (e == 6)) begin
                    errors++; $display("FAIL latency_full e=%0d: got %b expected %b", e, pins.water_full, e == 6);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            raw_d[CH_DRAINED] = pat[i];
            tick();
            checks++;
            if (pins.drained !== 1'b0 || obs !== exp_vec()) begin
                errors++; $display("FAIL bounce_hold i=%0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        raw_d[CH_DRAINED] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL bounce_model e=%0d: got %b expected %b", e, obs, exp_vec());
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (pins.drained !== (e == 6)) begin
                    errors++; $display("FAIL bounce_rise e=%0d: got %b expected %b", e, pins.drained, e == 6);
                end
            end
            if (e == 7) begin
                checks++;
                if (pins.sensor_err !== 1'b1) begin
                    errors++; $display("FAIL sensor_err_set: got %b expected 1", pins.sensor_err);
                end
            end
        end
        raw_d = 6'h00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 7) begin
                checks++;
                if (pins.sensor_err !== 1'b0 || obs !== exp_vec()) begin
                    errors++; $display("FAIL sensor_err_clear: got %b expected %b", obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_start(input logic door);
        int highs = 0;
        raw_d = 6'h00; raw_d[CH_DOOR] = door;
        for (int e = 0; e < 8; e++) tick();
        raw_d[CH_START] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (pins.start) highs++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL start_model door=%0b e=%0d: got %b expected %b", door, e, obs, exp_vec());
            end
`ifdef WASHER_IN_EDGE_EN
            if (e == 7) begin
                checks++;
                if (pins.start !== ~door) begin
                    errors++; $display("FAIL start_pulse_pos door=%0b: got %b expected %b", door, pins.start, ~door);
                end
            end
`endif
        end
        checks++;
`ifdef WASHER_IN_EDGE_EN
        if (highs != (door ? 0 : 1)) begin
            errors++; $display("FAIL start_pulse_count door=%0b: got %0d expected %0d", door, highs, door ? 0 : 1);
        end
`else
        if (highs != 5) begin
            errors++; $display("FAIL start_level_count door=%0b: got %0d expected 5", door, highs);
        end
`endif
    endtask

    task automatic test_simul();
        int s_hi = 0, c_hi = 0;
        raw_d = 6'h00;
        for (int e = 0; e < 8; e++) tick();
        raw_d[CH_START] = 1'b1; raw_d[CH_CANCEL] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (pins.start) s_hi++;
            if (pins.cancel) c_hi++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL simul_model e=%0d: got %b expected %b", e, obs, exp_vec());
            end
        end
        checks++;
`ifdef WASHER_IN_EDGE_EN
        if (s_hi != 0 || c_hi != 1) begin
            errors++; $display("FAIL simul_prio: got start=%0d cancel=%0d expected 0/1", s_hi, c_hi);
        end
`else
        if (s_hi != 5 || c_hi != 5) begin
            errors++; $display("FAIL simul_levels: got start=%0d cancel=%0d expected 5/5", s_hi, c_hi);
        end
`endif
    endtask

    task automatic test_reset_mid_debounce();
        raw_d = 6'h00;
        for (int e = 0; e < 8; e++) tick();
        raw_d[CH_DRY] = 1'b1;
        for (int e = 0; e < 4; e++) tick();   // dry counter now part-way
        rst_d = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b0100000) begin
            errors++; $display("FAIL midreset_vals: got %b expected %b", obs, 7'b0100000);
        end
        rst_d = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL midreset_model e=%0d: got %b expected %b", e, obs, exp_vec());
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (pins.dry_sensor !== (e == 6)) begin
                    errors++; $display("FAIL midreset_dry e=%0d: got %b expected %b", e, pins.dry_sensor, e == 6);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] mask;
        for (int n = 0; n < 600; n++) begin
            mask = 6'h00;
            for (int ch = 0; ch < 6; ch++) mask[ch] = ($urandom_range(0, 6) == 0);
            raw_d = raw_d ^ mask;
            rst_d = ($urandom_range(0, 249) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random n=%0d: got %b expected %b", n, obs, exp_vec());
            end
        end
        rst_d = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_bounce();
        test_start(1'b0);
        test_start(1'b1);
        test_simul();
        test_reset_mid_debounce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
